// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the shared IO/memory bus port.
// Latches the winning request, waits for io_ready (or a timeout) and returns a one-cycle ack.
module io_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic              m0_gnt,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              m1_gnt,
    output logic [ADDR_W-1:0] io_address,
    output logic [DATA_W-1:0] io_write_value,
    input  logic [DATA_W-1:0] io_read_value,
    output logic              io_write_en,
    output logic              io_read_en,
    output logic [2:0]        io_data_size,
    input  logic              io_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Last count value before the timeout fires; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t                       state_q, state_d;
    logic                         owner_q, owner_d;
    logic                         last_q, last_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [DATA_W-1:0]            wval_q, wval_d;
    logic [2:0]                   size_q, size_d;
    logic                         wen_q, wen_d;
    logic                         ren_q, ren_d;
    logic [1:0]                   gnt_q, gnt_d;
    logic [1:0]                   ack_q, ack_d;
    logic [1:0]                   err_q, err_d;
    logic [1:0][DATA_W-1:0]       rdata_q, rdata_d;
    logic                         win;
    logic                         win_we;

    // On a tie the master that did not win last time gets the bus.
    assign win    = (m0_req && m1_req) ? ~last_q : m1_req;
    assign win_we = win ? m1_we : m0_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
            wval_q  <= '0;
            size_q  <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wval_q  <= wval_d;
            size_q  <= size_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wval_d  = wval_q;
        size_d  = size_q;
        wen_d   = wen_q;
        ren_d   = ren_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = BUSY;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = '0;
                    addr_d  = win ? m1_addr : m0_addr;
                    wval_d  = win ? m1_wdata : m0_wdata;
                    size_d  = win ? m1_size : m0_size;
                    wen_d   = win_we;
                    ren_d   = ~win_we;
                    gnt_d   = win ? 2'b10 : 2'b01;
                end
            end
            BUSY: begin
                if (io_ready) begin
                    // Write acks leave the master's read data untouched.
                    if (ren_q) begin
                        rdata_d[owner_q] = io_read_value;
                    end
                    ack_d[owner_q] = 1'b1;
                    wen_d   = 1'b0;
                    ren_d   = 1'b0;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == TO_LAST) begin
                        rdata_d[owner_q] = '0;
                        ack_d[owner_q]   = 1'b1;
                        err_d[owner_q]   = 1'b1;
                        wen_d   = 1'b0;
                        ren_d   = 1'b0;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_rdata       = rdata_q[0];
    assign m1_rdata       = rdata_q[1];
    assign m0_ack         = ack_q[0];
    assign m1_ack         = ack_q[1];
    assign m0_err         = err_q[0];
    assign m1_err         = err_q[1];
    assign m0_gnt         = gnt_q[0];
    assign m1_gnt         = gnt_q[1];
    assign io_address     = addr_q;
    assign io_write_value = wval_q;
    assign io_data_size   = size_q;
    assign io_write_en    = wen_q;
    assign io_read_en     = ren_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: acks are checked by a monitor against an expected queue,
// bus-side and grant behaviour is checked inline by the stimulus thread.
module tb_io_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [2:0]        m0_size, m1_size;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_ack, m0_err, m0_gnt, m1_ack, m1_err, m1_gnt;
    logic [ADDR_W-1:0] io_address;
    logic [DATA_W-1:0] io_write_value, io_read_value;
    logic              io_write_en, io_read_en, io_ready;
    logic [2:0]        io_data_size;

    // Expected ack: {master, err, rdata}
    logic [DATA_W+1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    io_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_gnt(m0_gnt),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_gnt(m1_gnt),
        .io_address(io_address), .io_write_value(io_write_value),
        .io_read_value(io_read_value), .io_write_en(io_write_en),
        .io_read_en(io_read_en), .io_data_size(io_data_size), .io_ready(io_ready)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic master, input logic err, input logic [DATA_W-1:0] rd);
        exp_q.push_back({master, err, rd});
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_ack && m1_ack) begin
                check("both_acks", 64'd1, 64'd0);
            end else if (m0_ack || m1_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {31'd0, m1_ack, 32'd0}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("ack_resp",
                          {30'd0, m1_ack, (m1_ack ? m1_err : m0_err), (m1_ack ? m1_rdata : m0_rdata)},
                          {30'd0, exp_q.pop_front()});
                end
            end
            if ((m0_err && !m0_ack) || (m1_err && !m1_ack))
                check("err_without_ack", 64'd1, 64'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        io_read_value = 0; io_ready = 0;

        // Reset state
        repeat (3) step();
        check("rst_outputs", {m0_ack, m1_ack, m0_err, m1_err, m0_gnt, m1_gnt, io_write_en, io_read_en}, 64'd0);
        check("rst_io_address", io_address, 64'd0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        rst_n = 1'b1;
        step();

        // Single read by m0, zero-wait slave
        m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_size = 3'd2;
        io_ready = 1; io_read_value = 32'hDEAD_BEEF;
        step();
        check("rd_grant", {m0_gnt, m1_gnt, io_read_en, io_write_en}, 64'b1010);
        check("rd_addr", io_address, 64'h100);
        check("rd_size", io_data_size, 64'd2);
        push_exp(1'b0, 1'b0, 32'hDEAD_BEEF);
        step();
        m0_req = 0;
        check("rd_done_strobes", {m0_gnt, io_read_en, m1_ack, m1_err, m1_gnt}, 64'd0);
        step();
        step();

        // Tie: last winner was m0, so grants go 1, 0, 1, 0
        m0_req = 1; m0_we = 0; m0_addr = 32'h200; m0_size = 3'd2;
        m1_req = 1; m1_we = 0; m1_addr = 32'h300; m1_size = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_gnt", {m1_gnt, m0_gnt}, (i % 2 == 0) ? 64'b10 : 64'b01);
            check("rr_addr", io_address, (i % 2 == 0) ? 64'h300 : 64'h200);
            io_read_value = 32'hA000 + 32'(i);
            push_exp((i % 2 == 0), 1'b0, 32'hA000 + 32'(i));
            step();
            if (i == 3) begin
                m0_req = 0;
                m1_req = 0;
            end
        end
        step();

        // Wait states: m1 write with io_ready low for 3 cycles; address change ignored
        io_ready = 0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h55; m1_size = 3'd0;
        step();
        check("ws_grant", {m1_gnt, io_write_en, io_read_en}, 64'b110);
        m1_addr = 32'hFFF; m1_wdata = 32'h99;
        for (int k = 0; k < 3; k++) begin
            step();
            check("ws_hold", {io_write_en, m1_ack, io_address, io_write_value}, {2'b10, 32'h40, 32'h55});
        end
        io_ready = 1;
        push_exp(1'b1, 1'b0, 32'hA002);
        step();
        m1_req = 0;
        check("ws_done", {io_write_en, m1_gnt}, 64'd0);
        step();

        // Timeout: io_ready stuck low, 16 BUSY cycles
        io_ready = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h500; m0_size = 3'd2;
        step();
        check("to_grant", {m0_gnt, io_read_en}, 64'b11);
        m0_addr = 32'h504;
        for (int k = 0; k < 15; k++) begin
            step();
            check("to_wait", {m0_ack, io_read_en, io_address}, {2'b01, 32'h500});
        end
        push_exp(1'b0, 1'b1, 32'h0);
        step();
        check("to_strobes", {io_read_en, io_write_en, m0_gnt}, 64'd0);
        io_ready = 1; io_read_value = 32'h77;
        step();
        check("to_regrant", {m0_gnt, io_address}, {1'b1, 32'h504});
        m0_req = 0;
        push_exp(1'b0, 1'b0, 32'h77);
        step();
        step();

        // Reset mid-transfer: m1 wins the tie, then reset drops everything asynchronously
        io_ready = 0;
        m0_req = 1; m0_addr = 32'h600;
        m1_req = 1; m1_we = 0; m1_addr = 32'h700;
        step();
        check("mr_grant", {m1_gnt, m0_gnt}, 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async", {m0_gnt, m1_gnt, io_read_en, io_write_en, m0_ack, m1_ack}, 64'd0);
        step();
        io_ready = 1; io_read_value = 32'hBB;
        rst_n = 1'b1;
        step();
        check("mr_tie_m0_first", {m1_gnt, m0_gnt, io_address}, {2'b01, 32'h600});
        m0_req = 0; m1_req = 0;
        push_exp(1'b0, 1'b0, 32'hBB);
        step();
        repeat (3) step();

        check("queue_empty", exp_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
